// File: rtl/fc_layer_ctrl.sv
// Sequencer for one folded fully-connected layer: accepts an activation vector,
// sweeps fold_add across every slice, then holds the finished output until consumed.
module fc_layer_ctrl #(
  parameter int fold     = 64,
  parameter int fold_log = (fold > 1) ? $clog2(fold) : 1,
  parameter int hold     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                act_valid,
  output logic                act_ready,
  output logic                stream_act_en,
  input  logic                cfg_valid,
  input  logic                cfg_sel,
  input  logic [fold_log-1:0] cfg_addr,
  output logic                cfg_ready,
  output logic                stream_w_en,
  output logic [fold_log-1:0] stream_w_addr,
  output logic                stream_th_en,
  output logic [fold_log-1:0] stream_th_addr,
  output logic [fold_log-1:0] fold_add,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int HW = $clog2(hold) + 1;
  localparam logic [fold_log-1:0] SLICE_LAST = fold_log'(fold - 1);
  localparam logic [HW-1:0]       HOLD_LAST  = HW'(hold - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q;
  logic [fold_log-1:0] slice_q;
  logic [HW-1:0]       hcnt_q;
  logic                idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      slice_q <= '0;
      hcnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (stream_act_en) begin
            state_q <= RUN;
            slice_q <= '0;
            hcnt_q  <= '0;
          end
        end
        RUN: begin
          if (hcnt_q == HOLD_LAST) begin
            hcnt_q <= '0;
            // Final slice is left in place so DONE keeps presenting it.
            if (slice_q == SLICE_LAST) state_q <= DONE;
            else                       slice_q <= slice_q + fold_log'(1);
          end else begin
            hcnt_q <= hcnt_q + HW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
            slice_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign idle = (state_q == IDLE);

  // Configuration wins over activation; reset masks every strobe.
  assign act_ready      = idle & ~cfg_valid;
  assign cfg_ready      = idle;
  assign stream_act_en  = act_valid & act_ready & ~reset;
  assign stream_w_en    = idle & cfg_valid & ~cfg_sel & ~reset;
  assign stream_th_en   = idle & cfg_valid &  cfg_sel & ~reset;
  assign stream_w_addr  = cfg_addr;
  assign stream_th_addr = cfg_addr;
  assign fold_add       = idle ? '0 : slice_q;
  assign out_valid      = (state_q == DONE);
  assign busy           = ~idle;

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Directed bench for fc_layer_ctrl: main instance fold=4/hold=1, plus
// fold=4/hold=2 and fold=1/hold=1 instances sharing the same stimulus.
module tb_fc_layer_ctrl;

  logic       clk = 1'b0;
  logic       reset, act_valid, cfg_valid, cfg_sel, out_ready;
  logic [1:0] cfg_addr;

  logic       act_ready, stream_act_en, cfg_ready, stream_w_en, stream_th_en, out_valid, busy;
  logic [1:0] stream_w_addr, stream_th_addr, fold_add;

  logic       u2_act_ready, u2_act_en, u2_cfg_ready, u2_w_en, u2_th_en, u2_out_valid, u2_busy;
  logic [1:0] u2_w_addr, u2_th_addr, u2_fold_add;

  logic       u3_act_ready, u3_act_en, u3_cfg_ready, u3_w_en, u3_th_en, u3_out_valid, u3_busy;
  logic [0:0] u3_w_addr, u3_th_addr, u3_fold_add;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fc_layer_ctrl #(.fold(4), .hold(1)) dut (
    .clk(clk), .reset(reset), .act_valid(act_valid), .act_ready(act_ready),
    .stream_act_en(stream_act_en), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_ready(cfg_ready), .stream_w_en(stream_w_en),
    .stream_w_addr(stream_w_addr), .stream_th_en(stream_th_en),
    .stream_th_addr(stream_th_addr), .fold_add(fold_add), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  fc_layer_ctrl #(.fold(4), .hold(2)) dut_h2 (
    .clk(clk), .reset(reset), .act_valid(act_valid), .act_ready(u2_act_ready),
    .stream_act_en(u2_act_en), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_ready(u2_cfg_ready), .stream_w_en(u2_w_en),
    .stream_w_addr(u2_w_addr), .stream_th_en(u2_th_en),
    .stream_th_addr(u2_th_addr), .fold_add(u2_fold_add), .out_valid(u2_out_valid),
    .out_ready(out_ready), .busy(u2_busy)
  );

  fc_layer_ctrl #(.fold(1), .hold(1)) dut_f1 (
    .clk(clk), .reset(reset), .act_valid(act_valid), .act_ready(u3_act_ready),
    .stream_act_en(u3_act_en), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr[0:0]), .cfg_ready(u3_cfg_ready), .stream_w_en(u3_w_en),
    .stream_w_addr(u3_w_addr), .stream_th_en(u3_th_en),
    .stream_th_addr(u3_th_addr), .fold_add(u3_fold_add), .out_valid(u3_out_valid),
    .out_ready(out_ready), .busy(u3_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; act_valid = 1'b1; cfg_valid = 1'b0; cfg_sel = 1'b0;
    cfg_addr = 2'd0; out_ready = 1'b0;

    // Reset held 3 cycles with act_valid high
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_act_en", stream_act_en, 0);
    end
    check_eq("rst_act_ready", act_ready, 1);
    check_eq("rst_cfg_ready", cfg_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_fold_add", fold_add, 0);
    check_eq("rst_w_en", stream_w_en, 0);
    check_eq("rst_th_en", stream_th_en, 0);

    // First handshake right after reset drops, then basic run
    reset = 1'b0;
    #1 check_eq("first_hs", stream_act_en, 1);
    tick();
    act_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_eq("run_fold_add", fold_add, k);
      check_eq("run_busy", busy, 1);
      check_eq("run_out_valid", out_valid, 0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      check_eq("done_out_valid", out_valid, 1);
      check_eq("done_fold_add", fold_add, 3);
      check_eq("done_act_ready", act_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1 check_eq("accept_out_valid", out_valid, 1);
    tick();
    out_ready = 1'b0;
    check_eq("post_out_valid", out_valid, 0);
    check_eq("post_busy", busy, 0);
    check_eq("post_fold_add", fold_add, 0);
    check_eq("post_act_ready", act_ready, 1);

    // Configuration writes in IDLE
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_addr = 2'(i);
      #1;
      check_eq("cfg_w_en", stream_w_en, 1);
      check_eq("cfg_w_addr", stream_w_addr, i);
      check_eq("cfg_w_th_en", stream_th_en, 0);
      check_eq("cfg_fold_add", fold_add, 0);
      check_eq("cfg_ready", cfg_ready, 1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_addr = 2'(i);
      #1;
      check_eq("cfg_th_en", stream_th_en, 1);
      check_eq("cfg_th_addr", stream_th_addr, i);
      check_eq("cfg_th_w_en", stream_w_en, 0);
      tick();
    end
    cfg_valid = 1'b0;
    #1;
    check_eq("cfg_end_w_en", stream_w_en, 0);
    check_eq("cfg_end_th_en", stream_th_en, 0);
    tick();

    // Simultaneous cfg and activation in IDLE
    cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_addr = 2'd2; act_valid = 1'b1;
    #1;
    check_eq("sim_act_ready", act_ready, 0);
    check_eq("sim_act_en", stream_act_en, 0);
    check_eq("sim_w_en", stream_w_en, 1);
    check_eq("sim_w_addr", stream_w_addr, 2);
    tick();
    check_eq("sim_busy", busy, 0);
    check_eq("sim_w_en2", stream_w_en, 1);
    tick();
    cfg_valid = 1'b0;
    #1;
    check_eq("sim_act_ready_late", act_ready, 1);
    check_eq("sim_act_en_late", stream_act_en, 1);
    tick();
    act_valid = 1'b0; cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_addr = 2'd1;
    #1;
    check_eq("run_cfg_ready", cfg_ready, 0);
    check_eq("run_th_en", stream_th_en, 0);
    check_eq("run_busy2", busy, 1);
    for (int k = 0; k < 4; k++) tick();
    check_eq("done_out_valid2", out_valid, 1);
    check_eq("done_cfg_ready", cfg_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("ret_cfg_ready", cfg_ready, 1);
    check_eq("ret_th_en", stream_th_en, 1);
    check_eq("ret_th_addr", stream_th_addr, 1);
    cfg_valid = 1'b0;
    tick();

    // Mid-run reset while fold_add = 2
    act_valid = 1'b1;
    #1 check_eq("mr_hs", stream_act_en, 1);
    tick();
    act_valid = 1'b0;
    tick();
    tick();
    check_eq("mr_fold_add2", fold_add, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("mr_fold_add", fold_add, 0);
    check_eq("mr_busy", busy, 0);
    check_eq("mr_act_ready", act_ready, 1);
    for (int k = 0; k < 8; k++) begin
      check_eq("mr_no_valid", out_valid, 0);
      tick();
    end

    // Registered-memory timing (hold=2) and fold=1, handshake at cycle 0
    out_ready = 1'b1; act_valid = 1'b1;
    #1;
    check_eq("h2_hs", u2_act_en, 1);
    check_eq("f1_hs", u3_act_en, 1);
    tick();
    act_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check_eq("h2_fold_add", u2_fold_add, (c - 1) / 2);
      check_eq("h2_out_valid", u2_out_valid, 0);
      if (c == 1) check_eq("f1_run_valid", u3_out_valid, 0);
      if (c == 2) check_eq("f1_out_valid", u3_out_valid, 1);
      if (c == 3) check_eq("f1_idle", u3_busy, 0);
      tick();
    end
    check_eq("h2_out_valid9", u2_out_valid, 1);
    check_eq("h2_fold_add9", u2_fold_add, 3);
    tick();
    check_eq("h2_idle", u2_out_valid, 0);
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
